muldiv_unit: RTL and testbench

Iterative RV32M-style multiply/divide execution unit, parametrised in operand width. It sits beside the single-cycle ALU in the EX stage and takes operations whose opcode is `R_TYPE` and whose funct7 is 0000001. A valid/ready handshake on both sides lets the hazard unit stall the pipeline on `busy`. The result returns with its destination tag for write-back and forwarding.

---
 rtl/muldiv_unit.sv | 173 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, valid/ready on both sides.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiplier with a single-cycle combinational array.
module muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_f3,
   input  logic [XLEN-1:0]  in_a,
   input  logic [XLEN-1:0]  in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);
   localparam int CW = $clog2(XLEN + 1);
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t           state_q;
   logic [CW-1:0]    count_q;
   logic [2:0]       f3_q;
   logic             neg_q;
   logic [XLEN-1:0]  hi_q, lo_q, op_q, res_q;
   logic [TAG_W-1:0] tag_q;
   logic             in_ready_q, out_valid_q, busy_q;

   logic            is_div, a_signed, b_signed, a_neg, b_neg;
   logic            div_zero, div_ovf, special, neg_d, take_now;
   logic [XLEN-1:0] a_mag, b_mag, special_res, now_res;

   always_comb begin
      is_div      = in_f3[2];
      a_signed    = (in_f3 == 3'd1) || (in_f3 == 3'd2) || (in_f3 == 3'd4) || (in_f3 == 3'd6);
      b_signed    = (in_f3 == 3'd1) || (in_f3 == 3'd4) || (in_f3 == 3'd6);
      a_neg       = a_signed && in_a[XLEN-1];
      b_neg       = b_signed && in_b[XLEN-1];
      a_mag       = a_neg ? -in_a : in_a;
      b_mag       = b_neg ? -in_b : in_b;
      // Remainder takes the dividend's sign; everything else takes the product/quotient sign.
      neg_d       = (is_div && in_f3[1]) ? a_neg : (a_neg ^ b_neg);
      div_zero    = is_div && (in_b == '0);
      div_ovf     = is_div && !in_f3[0] && (in_a == MOST_NEG) && (in_b == '1);
      special     = div_zero || div_ovf;
      special_res = div_zero ? (in_f3[1] ? in_a : '1) : (in_f3[1] ? '0 : in_a);
   end

`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_a, fast_b, fast_p;
   always_comb begin
      // Low 2*XLEN bits of the sign-extended product equal the exact signed product.
      fast_a   = {{XLEN{a_neg}}, in_a};
      fast_b   = {{XLEN{b_neg}}, in_b};
      fast_p   = fast_a * fast_b;
      take_now = special || !is_div;
      if (is_div)
         now_res = special_res;
      else if (in_f3[1:0] == 2'd0)
         now_res = fast_p[XLEN-1:0];
      else
         now_res = fast_p[2*XLEN-1:XLEN];
   end
`else
   assign take_now = special;
   assign now_res  = special_res;
`endif

   logic [XLEN:0]     mul_sum, div_shift;
   logic              div_ge;
   logic [XLEN-1:0]   hi_d, lo_d, fin_val, res_d;
   logic [2*XLEN-1:0] prod_fix;

   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, op_q} : '0);
      div_shift = {hi_q, lo_q[XLEN-1]};
      div_ge    = div_shift >= {1'b0, op_q};
      if (f3_q[2]) begin
         hi_d = div_ge ? (div_shift[XLEN-1:0] - op_q) : div_shift[XLEN-1:0];
         lo_d = {lo_q[XLEN-2:0], div_ge};
      end else begin
         hi_d = mul_sum[XLEN:1];
         lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
      end
      prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
      fin_val  = f3_q[1] ? hi_q : lo_q;
      if (f3_q[2])
         res_d = neg_q ? -fin_val : fin_val;
      else if (f3_q[1:0] == 2'd0)
         res_d = prod_fix[XLEN-1:0];
      else
         res_d = prod_fix[2*XLEN-1:XLEN];
   end

   // XLEN iterations run at count 0..XLEN-1; the count==XLEN cycle applies the sign fix-up.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         f3_q        <= '0;
         neg_q       <= 1'b0;
         hi_q        <= '0;
         lo_q        <= '0;
         op_q        <= '0;
         res_q       <= '0;
         tag_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else if (flush) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  f3_q       <= in_f3;
                  tag_q      <= in_tag;
                  neg_q      <= neg_d;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  count_q    <= '0;
                  if (take_now) begin
                     res_q       <= now_res;
                     out_valid_q <= 1'b1;
                     state_q     <= S_DONE;
                  end else begin
                     hi_q    <= '0;
                     lo_q    <= is_div ? a_mag : b_mag;
                     op_q    <= is_div ? b_mag : a_mag;
                     state_q <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               count_q <= count_q + 1'b1;
               if (count_q == CW'(XLEN)) begin
                  res_q       <= res_d;
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end else begin
                  hi_q <= hi_d;
                  lo_q <= lo_d;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign busy       = busy_q;
   assign out_result = res_q;
   assign out_tag    = tag_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M cases plus randomized operations against a plain-arithmetic model.
module tb_muldiv_unit;
   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic [2:0]  in_f3;
   logic [31:0] in_a, in_b;
   logic [4:0]  in_tag;
   logic        in_ready, out_valid, busy;
   logic [31:0] out_result;
   logic [4:0]  out_tag;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  tag;
   } sb_t;
   sb_t exp_q[$];

   muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_f3(in_f3),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_tag(out_tag), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      longint sa, sb, ub;
      logic ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ub  = longint'({32'b0, b});
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Monitor: pops the scoreboard on every output handshake.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", {32'b0, out_result}, 64'hDEAD);
         end else begin
            sb_t e;
            e = exp_q.pop_front();
            $display("txn tag=%0d result=%08h expected=%08h", out_tag, out_result, e.res);
            check("result", {32'b0, out_result}, {32'b0, e.res});
            check("tag", {59'b0, out_tag}, {59'b0, e.tag});
         end
      end
   end

   task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input int hold);
      int n;
      int exp_lat;
      sb_t e;
      e.res   = model(f3, a, b);
      e.tag   = tag;
      exp_lat = 33;
      if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) exp_lat = 1;
`ifdef MULDIV_FAST_MUL_EN
      if (!f3[2]) exp_lat = 1;
`endif
      in_valid = 1'b1; in_f3 = f3; in_a = a; in_b = b; in_tag = tag;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin @(negedge clk); n++; end
      if (!in_ready) begin
         check("accept_timeout", 64'(n), 64'(0));
         in_valid = 1'b0;
         return;
      end
      exp_q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_tag = 5'($urandom);
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!out_valid && n < 100);
      check("latency", 64'(n), 64'(exp_lat));
      for (int i = 0; i < hold; i++) begin
         check("hold_valid", {63'b0, out_valid}, 64'd1);
         check("hold_result", {32'b0, out_result}, {32'b0, e.res});
         check("hold_in_ready", {63'b0, in_ready}, 64'd0);
         check("hold_busy", {63'b0, busy}, 64'd1);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("post_in_ready", {63'b0, in_ready}, 64'd1);
      check("post_out_valid", {63'b0, out_valid}, 64'd0);
      check("post_busy", {63'b0, busy}, 64'd0);
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] corners [5];
      logic [31:0] v;
      corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
      case ($urandom_range(0, 3))
         0: v = $urandom;
         1: v = $urandom_range(0, 20);
         2: begin v = $urandom_range(1, 20); v = -v; end
         default: v = corners[$urandom_range(0, 4)];
      endcase
      return v;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1);
   end

   initial begin
      int seen;
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_f3 = '0; in_a = '0; in_b = '0; in_tag = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", {63'b0, in_ready}, 64'd1);
      check("rst_out_valid", {63'b0, out_valid}, 64'd0);
      check("rst_busy", {63'b0, busy}, 64'd0);
      check("rst_result", {32'b0, out_result}, 64'd0);
      check("rst_tag", {59'b0, out_tag}, 64'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 0);
      do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 0);
      do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1);
      do_op(3'd4, -32'd20, 32'd3, 5'd3, 0);
      do_op(3'd6, -32'd20, 32'd3, 5'd4, 0);
      do_op(3'd5, 32'd100, 32'd7, 5'd6, 2);
      do_op(3'd5, 32'd9, 32'd0, 5'd7, 0);
      do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0);
      do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 0);
      do_op(3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 5'd10, 0);
      // Backpressure: result held for 10 cycles in DONE
      do_op(3'd7, 32'd1234567, 32'd1000, 5'd11, 10);

      // Flush at count 10
      in_valid = 1'b1; in_f3 = 3'd5; in_a = 32'd1000; in_b = 32'd7; in_tag = 5'd12;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("flush_busy_before", {63'b0, busy}, 64'd1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_in_ready", {63'b0, in_ready}, 64'd1);
      check("flush_busy", {63'b0, busy}, 64'd0);
      in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      check("flush_reject_busy", {63'b0, busy}, 64'd0);
      out_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      out_ready = 1'b0;
      check("flush_no_output", 64'(seen), 64'd0);

      // Asynchronous reset at count 5
      in_valid = 1'b1; in_f3 = 3'd4; in_a = -32'd50; in_b = 32'd3; in_tag = 5'd13;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("arst_in_ready", {63'b0, in_ready}, 64'd1);
      check("arst_busy", {63'b0, busy}, 64'd0);
      check("arst_out_valid", {63'b0, out_valid}, 64'd0);
      check("arst_result", {32'b0, out_result}, 64'd0);
      check("arst_tag", {59'b0, out_tag}, 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      do_op(3'd0, 32'd6, 32'd7, 5'd14, 0);

      for (int i = 0; i < 60; i++) begin
         do_op(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom), $urandom_range(0, 3));
      end

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
